// File: rtl/cpu_control_fsm_if.sv
// Control-unit bus: instruction/flag inputs and datapath control outputs.
// The master side (datapath or bench) drives memory data and flags; the slave side is the controller.
interface cpu_control_fsm_if #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 16
);
  localparam int SEL_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

  logic [DATA_W-1:0]  mem_in;
  logic [4:0]         flags;
  logic [DATA_W-1:0]  instr_out;
  logic [REG_CNT-1:0] reg_en;
  logic [SEL_W-1:0]   mux_a_sel;
  logic [SEL_W-1:0]   mux_b_sel;
  logic               addr_sel;
  logic [1:0]         pc_sel;
  logic               pc_en;
  logic [DATA_W-1:0]  disp_out;
  logic               imm_sel;
  logic               alu_sel;
  logic               mem_w_en;
  logic               flag_en;
  logic               illegal_op;
  logic [3:0]         state_out;

  modport master (
    output mem_in, flags,
    input  instr_out, reg_en, mux_a_sel, mux_b_sel, addr_sel, pc_sel, pc_en,
           disp_out, imm_sel, alu_sel, mem_w_en, flag_en, illegal_op, state_out
  );

  modport slave (
    input  mem_in, flags,
    output instr_out, reg_en, mux_a_sel, mux_b_sel, addr_sel, pc_sel, pc_en,
           disp_out, imm_sel, alu_sel, mem_w_en, flag_en, illegal_op, state_out
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit datapath.
// Control outputs are registered alongside the state; only pc_sel looks at the live flag bus.
module cpu_control_fsm #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 16,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  cpu_control_fsm_if.slave  bus
);
  localparam int SEL_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXEC_R    = 4'd3,
    ST_STORE     = 4'd4,
    ST_LOAD_ADDR = 4'd5,
    ST_LOAD_WB   = 4'd6,
    ST_JUMP      = 4'd7,
    ST_BRANCH    = 4'd8
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  disp;
    logic [REG_CNT-1:0] regEn;
    logic [SEL_W-1:0]   muxA;
    logic [SEL_W-1:0]   muxB;
    logic               addrSel;
    logic               pcEn;
    logic               immSel;
    logic               aluSel;
    logic               memWEn;
    logic               flagEn;
    logic               illegalOp;
  } ctrl_t;

  localparam logic [3:0] OP_RR     = 4'b0000;
  localparam logic [3:0] OP_MEM    = 4'b0100;
  localparam logic [3:0] OP_CMP    = 4'b1011;
  localparam logic [3:0] OP_BRANCH = 4'b1100;
  localparam logic [3:0] OP_MOV    = 4'b1101;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STORE = 4'b0100;
  localparam logic [3:0] EXT_JUMP  = 4'b1100;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_LAT - 1);

  state_t            r_state;
  logic [3:0]        r_wait;
  logic [DATA_W-1:0] r_instr;
  ctrl_t             r_ctrl;

  state_t            w_next;
  logic [DATA_W-1:0] w_nextInstr;
  logic              w_waitDone;
  logic              w_condTrue;

  // ST_FETCH as a dispatch result marks an undecodable memory-group extension.
  function automatic state_t dispatch(input logic [DATA_W-1:0] ins);
    if (ins[15:12] == OP_MEM) begin
      case (ins[7:4])
        EXT_LOAD:  return ST_LOAD_ADDR;
        EXT_STORE: return ST_STORE;
        EXT_JUMP:  return ST_JUMP;
        default:   return ST_FETCH;
      endcase
    end else if (ins[15:12] == OP_BRANCH) begin
      return ST_BRANCH;
    end
    return ST_EXEC_R;
  endfunction

  function automatic state_t nextState(input state_t s, input logic done,
                                       input logic [DATA_W-1:0] ins);
    case (s)
      ST_RESET:     return ST_FETCH;
      ST_FETCH:     return done ? ST_DECODE : ST_FETCH;
      ST_DECODE:    return dispatch(ins);
      ST_LOAD_ADDR: return done ? ST_LOAD_WB : ST_LOAD_ADDR;
      ST_EXEC_R, ST_STORE, ST_LOAD_WB, ST_JUMP, ST_BRANCH: return ST_FETCH;
      default:      return ST_RESET;
    endcase
  endfunction

  // Indices at or above REG_CNT match no bit, which suppresses the write.
  function automatic logic [REG_CNT-1:0] oneHot(input logic [3:0] idx);
    logic [REG_CNT-1:0] v;
    v = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      if (idx == 4'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic ctrl_t ctrlFor(input state_t s, input logic [DATA_W-1:0] ins);
    ctrl_t      c;
    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] dst;
    logic [3:0] src;
    logic       isCmp;
    logic       isMov;
    c     = '0;
    op    = ins[15:12];
    ext   = ins[7:4];
    dst   = ins[11:8];
    src   = ins[3:0];
    isCmp = (op == OP_CMP) || (op == OP_RR && ext == OP_CMP);
    isMov = (op == OP_MOV) || (op == OP_RR && ext == OP_MOV);
    case (s)
      ST_DECODE: begin
        c.muxA = dst[SEL_W-1:0];
        c.muxB = src[SEL_W-1:0];
        if (dispatch(ins) == ST_FETCH) begin
          c.illegalOp = 1'b1;
          c.pcEn      = 1'b1;
        end
      end
      ST_EXEC_R: begin
        c.muxA   = dst[SEL_W-1:0];
        c.muxB   = src[SEL_W-1:0];
        c.aluSel = 1'b1;
        c.immSel = (op != OP_RR);
        c.pcEn   = 1'b1;
        c.regEn  = isCmp ? '0 : oneHot(dst);
        c.flagEn = !isMov;
      end
      ST_STORE: begin
        c.muxA    = src[SEL_W-1:0];
        c.muxB    = dst[SEL_W-1:0];
        c.addrSel = 1'b1;
        c.memWEn  = 1'b1;
        c.pcEn    = 1'b1;
      end
      ST_LOAD_ADDR: begin
        c.muxA    = src[SEL_W-1:0];
        c.muxB    = src[SEL_W-1:0];
        c.addrSel = 1'b1;
      end
      ST_LOAD_WB: begin
        c.muxA  = dst[SEL_W-1:0];
        c.muxB  = src[SEL_W-1:0];
        c.regEn = oneHot(dst);
        c.pcEn  = 1'b1;
      end
      ST_JUMP: begin
        c.muxA = src[SEL_W-1:0];
        c.muxB = src[SEL_W-1:0];
        c.pcEn = 1'b1;
      end
      ST_BRANCH: begin
        c.muxA = dst[SEL_W-1:0];
        c.muxB = src[SEL_W-1:0];
        c.disp = {{(DATA_W-8){ins[7]}}, ins[7:0]};
        c.pcEn = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  // flags = {N, Z, F, L, C}
  function automatic logic condMet(input logic [3:0] code, input logic [4:0] fl);
    logic n, z, f, l, cy;
    {n, z, f, l, cy} = fl;
    case (code)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return l;
      4'h5: return !l;
      4'h6: return n;
      4'h7: return !n;
      4'h8: return f;
      4'h9: return !f;
      4'hA: return !l && !z;
      4'hB: return l || z;
      4'hC: return !n && !z;
      4'hD: return n || z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign w_waitDone  = (r_wait == WAIT_LAST);
  assign w_next      = nextState(r_state, w_waitDone, r_instr);
  assign w_nextInstr = (r_state == ST_FETCH && w_waitDone) ? bus.mem_in : r_instr;
  assign w_condTrue  = condMet(r_instr[11:8], bus.flags);

  // Outputs for the coming state are computed from the instruction that state will see.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RESET;
      r_wait  <= 4'd0;
      r_instr <= '0;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_instr <= w_nextInstr;
      r_ctrl  <= ctrlFor(w_next, w_nextInstr);
      if ((r_state == ST_FETCH || r_state == ST_LOAD_ADDR) && !w_waitDone)
        r_wait <= r_wait + 4'd1;
      else
        r_wait <= 4'd0;
    end
  end

  assign bus.instr_out  = r_instr;
  assign bus.reg_en     = r_ctrl.regEn;
  assign bus.mux_a_sel  = r_ctrl.muxA;
  assign bus.mux_b_sel  = r_ctrl.muxB;
  assign bus.addr_sel   = r_ctrl.addrSel;
  assign bus.pc_en      = r_ctrl.pcEn;
  assign bus.disp_out   = r_ctrl.disp;
  assign bus.imm_sel    = r_ctrl.immSel;
  assign bus.alu_sel    = r_ctrl.aluSel;
  assign bus.mem_w_en   = r_ctrl.memWEn;
  assign bus.flag_en    = r_ctrl.flagEn;
  assign bus.illegal_op = r_ctrl.illegalOp;
  assign bus.state_out  = r_state;

  // Taken jumps/branches must react to flags written just before, so this stays combinational.
  assign bus.pc_sel = !w_condTrue              ? 2'b00 :
                      (r_state == ST_JUMP)     ? 2'b01 :
                      (r_state == ST_BRANCH)   ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: three instances cover MEM_LAT=1, MEM_LAT=3 and REG_CNT=8.
module tb_cpu_control_fsm;
  logic clk = 1'b0;
  logic rst1, rst3, rst8;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cpu_control_fsm_if #(.DATA_W(16), .REG_CNT(16)) bus1 ();
  cpu_control_fsm_if #(.DATA_W(16), .REG_CNT(16)) bus3 ();
  cpu_control_fsm_if #(.DATA_W(16), .REG_CNT(8))  bus8 ();

  cpu_control_fsm #(.DATA_W(16), .REG_CNT(16), .MEM_LAT(1)) u1 (.clk(clk), .reset(rst1), .bus(bus1.slave));
  cpu_control_fsm #(.DATA_W(16), .REG_CNT(16), .MEM_LAT(3)) u3 (.clk(clk), .reset(rst3), .bus(bus3.slave));
  cpu_control_fsm #(.DATA_W(16), .REG_CNT(8),  .MEM_LAT(1)) u8 (.clk(clk), .reset(rst8), .bus(bus8.slave));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [15:0] instr, input logic [4:0] fl);
    case (which)
      1:       begin bus1.mem_in = instr; bus1.flags = fl; end
      3:       begin bus3.mem_in = instr; bus3.flags = fl; end
      default: begin bus8.mem_in = instr; bus8.flags = fl; end
    endcase
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst1 = 1'b0; rst3 = 1'b0; rst8 = 1'b0;
    applyStimulus(1, 16'h0513, 5'b0);
    applyStimulus(3, 16'h4204, 5'b0);
    applyStimulus(8, 16'h0A13, 5'b0);

    // Reset held low for three cycles
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("rst_state", 32'(bus1.state_out), 32'd0);
      checkOutput("rst_pc_en", 32'(bus1.pc_en), 32'd0);
    end
    checkOutput("rst_instr", 32'(bus1.instr_out), 32'd0);
    checkOutput("rst_reg_en", 32'(bus1.reg_en), 32'd0);

    // ADD R5,R3
    rst1 = 1'b1;
    stepCycle();
    checkOutput("add_fetch_state", 32'(bus1.state_out), 32'd1);
    checkOutput("add_fetch_pc_en", 32'(bus1.pc_en), 32'd0);
    stepCycle();
    checkOutput("add_dec_state", 32'(bus1.state_out), 32'd2);
    checkOutput("add_dec_instr", 32'(bus1.instr_out), 32'h0513);
    checkOutput("add_dec_mux_a", 32'(bus1.mux_a_sel), 32'd5);
    checkOutput("add_dec_mux_b", 32'(bus1.mux_b_sel), 32'd3);
    checkOutput("add_dec_pc_en", 32'(bus1.pc_en), 32'd0);
    stepCycle();
    checkOutput("add_exec_state", 32'(bus1.state_out), 32'd3);
    checkOutput("add_reg_en", 32'(bus1.reg_en), 32'h0020);
    checkOutput("add_flag_en", 32'(bus1.flag_en), 32'd1);
    checkOutput("add_imm_sel", 32'(bus1.imm_sel), 32'd0);
    checkOutput("add_alu_sel", 32'(bus1.alu_sel), 32'd1);
    checkOutput("add_pc_en", 32'(bus1.pc_en), 32'd1);
    checkOutput("add_pc_sel", 32'(bus1.pc_sel), 32'd0);

    // CMPI R2,#7
    applyStimulus(1, 16'hB207, 5'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("cmp_state", 32'(bus1.state_out), 32'd3);
    checkOutput("cmp_reg_en", 32'(bus1.reg_en), 32'd0);
    checkOutput("cmp_imm_sel", 32'(bus1.imm_sel), 32'd1);
    checkOutput("cmp_flag_en", 32'(bus1.flag_en), 32'd1);

    // JEQ R6 with Z=1, then Z=0
    applyStimulus(1, 16'h40C6, 5'b01000);
    stepCycle();
    stepCycle();
    checkOutput("jeq_dec_illegal", 32'(bus1.illegal_op), 32'd0);
    stepCycle();
    checkOutput("jeq_t_state", 32'(bus1.state_out), 32'd7);
    checkOutput("jeq_t_pc_sel", 32'(bus1.pc_sel), 32'd1);
    checkOutput("jeq_t_pc_en", 32'(bus1.pc_en), 32'd1);
    checkOutput("jeq_t_mux_a", 32'(bus1.mux_a_sel), 32'd6);
    applyStimulus(1, 16'h40C6, 5'b00000);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("jeq_nt_state", 32'(bus1.state_out), 32'd7);
    checkOutput("jeq_nt_pc_sel", 32'(bus1.pc_sel), 32'd0);
    checkOutput("jeq_nt_pc_en", 32'(bus1.pc_en), 32'd1);

    // Branch always, displacement -2
    applyStimulus(1, 16'hCEFE, 5'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("br_state", 32'(bus1.state_out), 32'd8);
    checkOutput("br_pc_sel", 32'(bus1.pc_sel), 32'd2);
    checkOutput("br_disp", 32'(bus1.disp_out), 32'hFFFE);
    checkOutput("br_pc_en", 32'(bus1.pc_en), 32'd1);

    // STORE R3 -> [R1], reset dropped during the store cycle
    applyStimulus(1, 16'h4341, 5'b0);
    stepCycle();
    checkOutput("st_fetch_disp", 32'(bus1.disp_out), 32'd0);
    stepCycle();
    stepCycle();
    checkOutput("st_state", 32'(bus1.state_out), 32'd4);
    checkOutput("st_mem_w_en", 32'(bus1.mem_w_en), 32'd1);
    checkOutput("st_addr_sel", 32'(bus1.addr_sel), 32'd1);
    checkOutput("st_mux_a", 32'(bus1.mux_a_sel), 32'd1);
    checkOutput("st_mux_b", 32'(bus1.mux_b_sel), 32'd3);
    rst1 = 1'b0;
    stepCycle();
    checkOutput("st_abort_state", 32'(bus1.state_out), 32'd0);
    checkOutput("st_abort_mem_w_en", 32'(bus1.mem_w_en), 32'd0);
    checkOutput("st_abort_pc_en", 32'(bus1.pc_en), 32'd0);

    // LOAD R2,[R4] with MEM_LAT=3: 3 fetch + decode + 3 address + writeback
    rst3 = 1'b1;
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      checkOutput("ld_fetch_state", 32'(bus3.state_out), 32'd1);
      checkOutput("ld_fetch_addr_sel", 32'(bus3.addr_sel), 32'd0);
      stepCycle();
    end
    checkOutput("ld_dec_state", 32'(bus3.state_out), 32'd2);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      checkOutput("ld_addr_state", 32'(bus3.state_out), 32'd5);
      checkOutput("ld_addr_sel", 32'(bus3.addr_sel), 32'd1);
      checkOutput("ld_addr_mux_a", 32'(bus3.mux_a_sel), 32'd4);
      checkOutput("ld_addr_pc_en", 32'(bus3.pc_en), 32'd0);
      stepCycle();
    end
    checkOutput("ld_wb_state", 32'(bus3.state_out), 32'd6);
    checkOutput("ld_wb_alu_sel", 32'(bus3.alu_sel), 32'd0);
    checkOutput("ld_wb_reg_en", 32'(bus3.reg_en), 32'h0004);
    checkOutput("ld_wb_pc_en", 32'(bus3.pc_en), 32'd1);
    stepCycle();
    checkOutput("ld_next_fetch", 32'(bus3.state_out), 32'd1);

    // REG_CNT=8: out-of-range destination, then illegal extension
    rst8 = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("oor_mux_a", 32'(bus8.mux_a_sel), 32'd2);
    checkOutput("oor_mux_b", 32'(bus8.mux_b_sel), 32'd3);
    stepCycle();
    checkOutput("oor_state", 32'(bus8.state_out), 32'd3);
    checkOutput("oor_reg_en", 32'(bus8.reg_en), 32'd0);
    checkOutput("oor_flag_en", 32'(bus8.flag_en), 32'd1);
    checkOutput("oor_pc_en", 32'(bus8.pc_en), 32'd1);
    applyStimulus(8, 16'h4074, 5'b0);
    stepCycle();
    stepCycle();
    checkOutput("ill_state", 32'(bus8.state_out), 32'd2);
    checkOutput("ill_pulse", 32'(bus8.illegal_op), 32'd1);
    checkOutput("ill_pc_en", 32'(bus8.pc_en), 32'd1);
    checkOutput("ill_pc_sel", 32'(bus8.pc_sel), 32'd0);
    stepCycle();
    checkOutput("ill_back_fetch", 32'(bus8.state_out), 32'd1);
    checkOutput("ill_pulse_end", 32'(bus8.illegal_op), 32'd0);
    checkOutput("ill_pc_en_end", 32'(bus8.pc_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
